// File: rtl/apb_pkg.sv
// Shared FSM/error encodings and the default SoC address map for the APB interconnect.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } apb_state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_UNMAPPED = 2'b01,
    ERR_TIMEOUT  = 2'b10,
    ERR_SLAVE    = 2'b11
  } apb_err_e;

  localparam int unsigned SOC_AW = 32;

  // Default SoC windows: slave matches when (paddr & MASK) == BASE.
  localparam logic [SOC_AW-1:0] SRAM_BASE  = 32'h8000_0000;
  localparam logic [SOC_AW-1:0] SRAM_MASK  = 32'h8000_0000;
  localparam logic [SOC_AW-1:0] UART_BASE  = 32'h1000_0000;
  localparam logic [SOC_AW-1:0] UART_MASK  = 32'hFFFF_0000;
  localparam logic [SOC_AW-1:0] SYS_BASE   = 32'h0000_0000;
  localparam logic [SOC_AW-1:0] SYS_MASK   = 32'hFFF0_0000;
  localparam logic [SOC_AW-1:0] INTC_BASE  = 32'h1001_0000;
  localparam logic [SOC_AW-1:0] INTC_MASK  = 32'hFFFF_0000;
  localparam logic [SOC_AW-1:0] TIMER_BASE = 32'h1002_0000;
  localparam logic [SOC_AW-1:0] TIMER_MASK = 32'hFFFF_0000;

endpackage

// File: rtl/apb_interconnect_if.sv
// CPU-side APB bus between the master and the interconnect.
interface apb_interconnect_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] APB_paddr;
  logic                  APB_psel;
  logic                  APB_penable;
  logic                  APB_pwrite;
  logic [3:0]            APB_pstb;
  logic [DATA_WIDTH-1:0] APB_prdata;
  logic                  APB_pready;
  logic                  APB_perr;

  modport master (
    output APB_paddr, APB_psel, APB_penable, APB_pwrite, APB_pstb,
    input  APB_prdata, APB_pready, APB_perr
  );

  modport slave (
    input  APB_paddr, APB_psel, APB_penable, APB_pwrite, APB_pstb,
    output APB_prdata, APB_pready, APB_perr
  );
endinterface

// File: rtl/apb_addr_decode.sv
// Table-driven address decoder: mask/compare per slave, lowest index wins.
module apb_addr_decode #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned NUM_SLAVES = 5,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = '0
) (
  input  logic [ADDR_WIDTH-1:0] paddr_i,
  output logic [NUM_SLAVES-1:0] hit_c,
  output logic                  mapped_c
);

  // Walk from highest to lowest index so the lowest matching slave overwrites the rest.
  always_comb begin
    hit_c    = '0;
    mapped_c = 1'b0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((paddr_i & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
          SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        hit_c    = '0;
        hit_c[i] = 1'b1;
        mapped_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_interconnect.sv
// APB interconnect: address-mapped fan-out with transfer timeout and sticky error capture.
module apb_interconnect
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_SLAVES     = 5,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = '0,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                             clk,
  input  logic                             APB_PRESETn,
  apb_interconnect_if.slave                bus,
  output logic [NUM_SLAVES-1:0]            s_psel,
  output logic [NUM_SLAVES-1:0]            s_penable,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_prdata,
  input  logic [NUM_SLAVES-1:0]            s_pready,
  input  logic [NUM_SLAVES-1:0]            s_perr,
  input  logic                             err_clr,
  output logic                             err_valid,
  output logic [1:0]                       err_code,
  output logic [ADDR_WIDTH-1:0]            err_addr
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  apb_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_SLAVES-1:0] hit_q, hit_d, dec_hit;
  logic                  mapped_q, mapped_d, dec_mapped;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  err_valid_q, err_valid_d;
  apb_err_e              err_code_q, err_code_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;

  logic                  tgt_ready_c, tgt_err_c;
  logic [DATA_WIDTH-1:0] tgt_rdata_c;
  logic                  pready_c, perr_c;
  logic [DATA_WIDTH-1:0] prdata_c;
  logic [NUM_SLAVES-1:0] s_psel_c, s_penable_c;
  apb_err_e              evt_code_c;
  logic [ADDR_WIDTH-1:0] evt_addr_c;
  logic                  unused_bus;

  // Write direction and strobes go to the slaves outside this block.
  assign unused_bus = ^{bus.APB_pwrite, bus.APB_pstb};

  apb_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_SLAVES (NUM_SLAVES),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_decode (
    .paddr_i  (bus.APB_paddr),
    .hit_c    (dec_hit),
    .mapped_c (dec_mapped)
  );

  // Response mux from the selected slave.
  always_comb begin
    tgt_ready_c = |(s_pready & hit_q);
    tgt_err_c   = |(s_perr & hit_q);
    tgt_rdata_c = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (hit_q[i]) tgt_rdata_c = tgt_rdata_c | s_prdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Transfer FSM: next state, slave strobes and master response.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hit_d       = hit_q;
    mapped_d    = mapped_q;
    addr_d      = addr_q;
    pready_c    = 1'b0;
    perr_c      = 1'b0;
    prdata_c    = '0;
    s_psel_c    = '0;
    s_penable_c = '0;
    evt_code_c  = ERR_UNMAPPED;
    evt_addr_c  = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.APB_psel && !bus.APB_penable) begin
          hit_d    = dec_hit;
          mapped_d = dec_mapped;
          addr_d   = bus.APB_paddr;
          cnt_d    = '0;
          state_d  = ST_ACCESS;
        end else if (bus.APB_psel && bus.APB_penable && APB_PRESETn) begin
          // Access phase with no setup seen (e.g. after reset): reject it.
          pready_c   = 1'b1;
          perr_c     = 1'b1;
          evt_addr_c = bus.APB_paddr;
        end
      end
      ST_ACCESS: begin
        s_psel_c    = hit_q & {NUM_SLAVES{bus.APB_psel}};
        s_penable_c = hit_q & {NUM_SLAVES{bus.APB_penable}};
        if (mapped_q) begin
          pready_c   = tgt_ready_c;
          perr_c     = tgt_err_c;
          prdata_c   = tgt_rdata_c;
          evt_code_c = ERR_SLAVE;
          if (tgt_ready_c) begin
            state_d = ST_IDLE;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_RESP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          pready_c = 1'b1;
          perr_c   = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_RESP: begin
        pready_c   = 1'b1;
        perr_c     = 1'b1;
        evt_code_c = ERR_TIMEOUT;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sticky error capture; a new error wins over a coincident clear.
  always_comb begin
    err_valid_d = err_valid_q;
    err_code_d  = err_code_q;
    err_addr_d  = err_addr_q;
    if (pready_c && perr_c && (!err_valid_q || err_clr)) begin
      err_valid_d = 1'b1;
      err_code_d  = evt_code_c;
      err_addr_d  = evt_addr_c;
    end else if (err_clr) begin
      err_valid_d = 1'b0;
      err_code_d  = ERR_NONE;
      err_addr_d  = '0;
    end
  end

  // State and capture registers.
  always_ff @(posedge clk or negedge APB_PRESETn) begin
    if (!APB_PRESETn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      hit_q       <= '0;
      mapped_q    <= 1'b0;
      addr_q      <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      err_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hit_q       <= hit_d;
      mapped_q    <= mapped_d;
      addr_q      <= addr_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign bus.APB_pready = pready_c;
  assign bus.APB_perr   = perr_c;
  assign bus.APB_prdata = prdata_c;
  assign s_psel         = s_psel_c;
  assign s_penable      = s_penable_c;
  assign err_valid      = err_valid_q;
  assign err_code       = err_code_q;
  assign err_addr       = err_addr_q;

endmodule

// File: tb/tb_apb_interconnect.sv
// Directed bench for apb_interconnect: 3 slaves (slave2 overlaps slave0), 8-cycle timeout.
module tb_apb_interconnect;
  import apb_pkg::*;

  localparam int unsigned NS = 3;
  localparam logic [NS*32-1:0] BASES = {32'h8000_0000, UART_BASE, SRAM_BASE};
  localparam logic [NS*32-1:0] MASKS = {32'hF000_0000, UART_MASK, SRAM_MASK};

  logic              clk;
  logic              rst_n;
  logic [NS-1:0]     s_psel, s_penable, s_pready, s_perr;
  logic [NS*32-1:0]  s_prdata;
  logic              err_clr, err_valid;
  logic [1:0]        err_code;
  logic [31:0]       err_addr;
  int                vec;
  int                miss;

  apb_interconnect_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  apb_interconnect #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(NS),
    .SLAVE_BASE(BASES), .SLAVE_MASK(MASKS), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .APB_PRESETn(rst_n), .bus(bus),
    .s_psel(s_psel), .s_penable(s_penable), .s_prdata(s_prdata),
    .s_pready(s_pready), .s_perr(s_perr), .err_clr(err_clr),
    .err_valid(err_valid), .err_code(err_code), .err_addr(err_addr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic bus_setup(input logic [31:0] addr, input logic wr);
    bus.APB_psel = 1'b1; bus.APB_penable = 1'b0; bus.APB_paddr = addr; bus.APB_pwrite = wr;
  endtask

  task automatic bus_idle();
    bus.APB_psel = 1'b0; bus.APB_penable = 1'b0; s_pready = '0; s_perr = '0; err_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vec++; if (bus.APB_pready !== 1'b0) begin miss++; $display("FAIL rst_pready got %b exp 0", bus.APB_pready); end
    vec++; if (bus.APB_perr !== 1'b0) begin miss++; $display("FAIL rst_perr got %b exp 0", bus.APB_perr); end
    vec++; if (bus.APB_prdata !== 32'h0) begin miss++; $display("FAIL rst_prdata got %h exp 0", bus.APB_prdata); end
    vec++; if (s_psel !== 3'b000) begin miss++; $display("FAIL rst_psel got %b exp 000", s_psel); end
    vec++; if (err_valid !== 1'b0) begin miss++; $display("FAIL rst_err_valid got %b exp 0", err_valid); end
    vec++; if (err_code !== 2'b00) begin miss++; $display("FAIL rst_err_code got %b exp 00", err_code); end
    vec++; if (err_addr !== 32'h0) begin miss++; $display("FAIL rst_err_addr got %h exp 0", err_addr); end
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_mapped_read();
    next_cycle(); bus_setup(32'h8000_0010, 1'b0); s_prdata = {32'h2222_2222, 32'h1111_1111, 32'hDEAD_BEEF};
    sample();
    vec++; if (s_psel !== 3'b000) begin miss++; $display("FAIL rd_setup_psel got %b exp 000", s_psel); end
    for (int k = 0; k < 2; k++) begin
      next_cycle(); bus.APB_penable = 1'b1; s_pready = 3'b010;
      sample();
      vec++; if (s_psel !== 3'b001 || s_penable !== 3'b001) begin miss++; $display("FAIL rd_wait_sel got %b/%b exp 001/001", s_psel, s_penable); end
      vec++; if (bus.APB_pready !== 1'b0) begin miss++; $display("FAIL rd_wait_pready got %b exp 0", bus.APB_pready); end
    end
    next_cycle(); s_pready = 3'b011;
    sample();
    vec++; if (bus.APB_pready !== 1'b1) begin miss++; $display("FAIL rd_done_pready got %b exp 1", bus.APB_pready); end
    vec++; if (bus.APB_prdata !== 32'hDEAD_BEEF) begin miss++; $display("FAIL rd_prdata got %h exp deadbeef", bus.APB_prdata); end
    vec++; if (bus.APB_perr !== 1'b0) begin miss++; $display("FAIL rd_perr got %b exp 0", bus.APB_perr); end
    next_cycle(); bus_idle();
    sample();
    vec++; if (bus.APB_pready !== 1'b0 || s_psel !== 3'b000) begin miss++; $display("FAIL rd_after got %b/%b exp 0/000", bus.APB_pready, s_psel); end
    vec++; if (err_valid !== 1'b0) begin miss++; $display("FAIL rd_err_valid got %b exp 0", err_valid); end
  endtask

  task automatic test_unmapped();
    next_cycle(); bus_setup(32'h2000_0000, 1'b1); s_prdata = {3{32'h5555_5555}}; s_pready = 3'b111;
    sample();
    vec++; if (s_psel !== 3'b000) begin miss++; $display("FAIL um_setup_psel got %b exp 000", s_psel); end
    next_cycle(); bus.APB_penable = 1'b1;
    sample();
    vec++; if (bus.APB_pready !== 1'b1 || bus.APB_perr !== 1'b1) begin miss++; $display("FAIL um_resp got %b/%b exp 1/1", bus.APB_pready, bus.APB_perr); end
    vec++; if (bus.APB_prdata !== 32'h0) begin miss++; $display("FAIL um_prdata got %h exp 0", bus.APB_prdata); end
    vec++; if (s_psel !== 3'b000) begin miss++; $display("FAIL um_psel got %b exp 000", s_psel); end
    next_cycle(); bus_idle();
    sample();
    vec++; if (err_valid !== 1'b1) begin miss++; $display("FAIL um_err_valid got %b exp 1", err_valid); end
    vec++; if (err_code !== 2'b01) begin miss++; $display("FAIL um_err_code got %b exp 01", err_code); end
    vec++; if (err_addr !== 32'h2000_0000) begin miss++; $display("FAIL um_err_addr got %h exp 20000000", err_addr); end
  endtask

  task automatic test_err_clear();
    next_cycle(); err_clr = 1'b1;
    next_cycle(); err_clr = 1'b0;
    sample();
    vec++; if (err_valid !== 1'b0) begin miss++; $display("FAIL clr_err_valid got %b exp 0", err_valid); end
  endtask

  task automatic test_timeout();
    next_cycle(); bus_setup(32'h1000_0020, 1'b0); s_prdata = {32'h2222_2222, 32'h1111_1111, 32'hDEAD_BEEF}; s_pready = 3'b001;
    for (int k = 1; k <= 8; k++) begin
      next_cycle(); bus.APB_penable = 1'b1;
      sample();
      vec++; if (bus.APB_pready !== 1'b0 || s_psel !== 3'b010) begin miss++; $display("FAIL to_wait%0d got %b/%b exp 0/010", k, bus.APB_pready, s_psel); end
    end
    next_cycle();
    sample();
    vec++; if (bus.APB_pready !== 1'b1 || bus.APB_perr !== 1'b1) begin miss++; $display("FAIL to_resp got %b/%b exp 1/1", bus.APB_pready, bus.APB_perr); end
    vec++; if (s_psel !== 3'b000 || s_penable !== 3'b000) begin miss++; $display("FAIL to_resp_sel got %b/%b exp 000/000", s_psel, s_penable); end
    vec++; if (bus.APB_prdata !== 32'h0) begin miss++; $display("FAIL to_prdata got %h exp 0", bus.APB_prdata); end
    next_cycle(); bus_idle(); s_pready = 3'b010;
    sample();
    vec++; if (bus.APB_pready !== 1'b0 || bus.APB_perr !== 1'b0) begin miss++; $display("FAIL to_late got %b/%b exp 0/0", bus.APB_pready, bus.APB_perr); end
    vec++; if (err_valid !== 1'b1 || err_code !== 2'b10) begin miss++; $display("FAIL to_err got %b/%b exp 1/10", err_valid, err_code); end
    vec++; if (err_addr !== 32'h1000_0020) begin miss++; $display("FAIL to_err_addr got %h exp 10000020", err_addr); end
    next_cycle(); s_pready = '0;
  endtask

  task automatic test_sticky();
    next_cycle(); bus_setup(32'h3000_0000, 1'b0);
    next_cycle(); bus.APB_penable = 1'b1;
    sample();
    vec++; if (bus.APB_perr !== 1'b1) begin miss++; $display("FAIL st_um_perr got %b exp 1", bus.APB_perr); end
    next_cycle(); bus_idle();
    sample();
    vec++; if (err_code !== 2'b10 || err_addr !== 32'h1000_0020) begin miss++; $display("FAIL st_keep got %b/%h exp 10/10000020", err_code, err_addr); end
    next_cycle(); bus_setup(32'h1000_0004, 1'b1);
    next_cycle(); bus.APB_penable = 1'b1; s_pready = 3'b010; s_perr = 3'b010; err_clr = 1'b1;
    sample();
    vec++; if (bus.APB_pready !== 1'b1 || bus.APB_perr !== 1'b1) begin miss++; $display("FAIL st_slverr got %b/%b exp 1/1", bus.APB_pready, bus.APB_perr); end
    next_cycle(); bus_idle();
    sample();
    vec++; if (err_valid !== 1'b1 || err_code !== 2'b11) begin miss++; $display("FAIL st_clr_new got %b/%b exp 1/11", err_valid, err_code); end
    vec++; if (err_addr !== 32'h1000_0004) begin miss++; $display("FAIL st_clr_addr got %h exp 10000004", err_addr); end
  endtask

  task automatic test_back_to_back();
    next_cycle(); bus_setup(32'h1000_0000, 1'b0); s_prdata = {32'h2222_2222, 32'h1111_1111, 32'hDEAD_BEEF};
    next_cycle(); bus.APB_penable = 1'b1; s_pready = 3'b010;
    sample();
    vec++; if (bus.APB_pready !== 1'b1 || bus.APB_prdata !== 32'h1111_1111) begin miss++; $display("FAIL b2b_first got %b/%h exp 1/11111111", bus.APB_pready, bus.APB_prdata); end
    next_cycle(); bus_setup(32'h8000_0004, 1'b0); s_pready = '0;
    sample();
    vec++; if (bus.APB_pready !== 1'b0 || s_psel !== 3'b000) begin miss++; $display("FAIL b2b_setup got %b/%b exp 0/000", bus.APB_pready, s_psel); end
    next_cycle(); bus.APB_penable = 1'b1; s_pready = 3'b001;
    sample();
    vec++; if (bus.APB_pready !== 1'b1 || bus.APB_prdata !== 32'hDEAD_BEEF || s_psel !== 3'b001) begin miss++; $display("FAIL b2b_second got %b/%h/%b exp 1/deadbeef/001", bus.APB_pready, bus.APB_prdata, s_psel); end
    next_cycle(); bus_idle();
  endtask

  task automatic test_overlap();
    next_cycle(); bus_setup(32'h8000_0000, 1'b0); s_prdata = {32'h2222_2222, 32'h1111_1111, 32'hA5A5_A5A5};
    next_cycle(); bus.APB_penable = 1'b1; s_pready = 3'b101;
    sample();
    vec++; if (s_psel !== 3'b001) begin miss++; $display("FAIL ov_psel got %b exp 001", s_psel); end
    vec++; if (bus.APB_prdata !== 32'hA5A5_A5A5) begin miss++; $display("FAIL ov_prdata got %h exp a5a5a5a5", bus.APB_prdata); end
    next_cycle(); bus_idle();
  endtask

  task automatic test_reset_mid();
    next_cycle(); bus_setup(32'h1000_0008, 1'b0); s_prdata = {32'h2222_2222, 32'h1111_1111, 32'hDEAD_BEEF};
    next_cycle(); bus.APB_penable = 1'b1;
    sample();
    vec++; if (s_psel !== 3'b010) begin miss++; $display("FAIL rm_pre_psel got %b exp 010", s_psel); end
    #1 rst_n = 1'b0;
    #1;
    vec++; if (s_psel !== 3'b000 || s_penable !== 3'b000) begin miss++; $display("FAIL rm_async_sel got %b/%b exp 000/000", s_psel, s_penable); end
    vec++; if (bus.APB_pready !== 1'b0 || bus.APB_perr !== 1'b0) begin miss++; $display("FAIL rm_async_resp got %b/%b exp 0/0", bus.APB_pready, bus.APB_perr); end
    vec++; if (err_valid !== 1'b0) begin miss++; $display("FAIL rm_async_err got %b exp 0", err_valid); end
    next_cycle(); rst_n = 1'b1;
    sample();
    vec++; if (bus.APB_pready !== 1'b1 || bus.APB_perr !== 1'b1 || bus.APB_prdata !== 32'h0) begin miss++; $display("FAIL rm_violation got %b/%b/%h exp 1/1/0", bus.APB_pready, bus.APB_perr, bus.APB_prdata); end
    vec++; if (s_psel !== 3'b000) begin miss++; $display("FAIL rm_violation_psel got %b exp 000", s_psel); end
    next_cycle(); bus_idle();
    sample();
    vec++; if (bus.APB_pready !== 1'b0) begin miss++; $display("FAIL rm_once got %b exp 0", bus.APB_pready); end
    vec++; if (err_valid !== 1'b1 || err_code !== 2'b01) begin miss++; $display("FAIL rm_err got %b/%b exp 1/01", err_valid, err_code); end
    next_cycle(); bus_setup(32'h1000_0000, 1'b0);
    next_cycle(); bus.APB_penable = 1'b1; s_pready = 3'b010;
    sample();
    vec++; if (bus.APB_pready !== 1'b1 || bus.APB_perr !== 1'b0 || bus.APB_prdata !== 32'h1111_1111) begin miss++; $display("FAIL rm_normal got %b/%b/%h exp 1/0/11111111", bus.APB_pready, bus.APB_perr, bus.APB_prdata); end
    next_cycle(); bus_idle();
  endtask

  initial begin
    vec = 0;
    miss = 0;
    rst_n = 1'b0;
    bus.APB_paddr = '0;
    bus.APB_psel = 1'b0;
    bus.APB_penable = 1'b0;
    bus.APB_pwrite = 1'b0;
    bus.APB_pstb = 4'hF;
    s_prdata = '0;
    s_pready = '0;
    s_perr = '0;
    err_clr = 1'b0;
    test_reset();
    test_mapped_read();
    test_unmapped();
    test_err_clear();
    test_timeout();
    test_sticky();
    test_back_to_back();
    test_overlap();
    test_reset_mid();
    test_err_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
